// File: rtl/ecsm_pkg.sv
// ecsm_pkg: FSM states, default sizes and counter width for ec_scalar_mult_p.
// Shared by the multiplier core and anything that sizes against it.
package ecsm_pkg;

  localparam int ECSM_WIDTH = 256;
  localparam int ECSM_KBITS = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_ADD_WAIT,
    S_DBL_WAIT,
    S_DONE
  } ecsm_state_e;

  function automatic int ecsm_cw(input int kbits);
    return $clog2(kbits + 1);
  endfunction

endpackage

// File: rtl/ec_scalar_mult_p.sv
// ec_scalar_mult_p: R = k*P by right-to-left double-and-add on an external point unit.
// Define ECSM_CONST_TIME_EN for add+double on every bit; default exits early.
module ec_scalar_mult_p
  import ecsm_pkg::*;
#(
  parameter int WIDTH = ECSM_WIDTH,
  parameter int KBITS = ECSM_KBITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] px,
  input  logic [WIDTH-1:0] py,
  input  logic [KBITS-1:0] k,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rx,
  output logic [WIDTH-1:0] ry,
  output logic             r_inf,
  output logic             add_start,
  output logic [WIDTH-1:0] add_ax,
  output logic [WIDTH-1:0] add_ay,
  output logic [WIDTH-1:0] add_bx,
  output logic [WIDTH-1:0] add_by,
  input  logic             add_done,
  input  logic [WIDTH-1:0] add_rx,
  input  logic [WIDTH-1:0] add_ry,
  input  logic             add_rinf
);

  localparam int CW = ecsm_cw(KBITS);
  localparam logic [KBITS-1:0] K_ONE = KBITS'(1);

  ecsm_state_e r_state, w_nstate;

  logic [KBITS-1:0] r_k;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_qx, r_qy;
  logic [WIDTH-1:0] r_rx, r_ry;
  logic             r_rinf;
  logic             r_start;
  logic [WIDTH-1:0] r_ax, r_ay, r_bx, r_by;

  logic w_kbit, w_fin;
  logic w_load, w_iss_add, w_iss_dbl;
  logic w_r_q, w_r_unit, w_q_unit;

  assign w_kbit = |(r_k & (K_ONE << r_cnt));

`ifdef ECSM_CONST_TIME_EN
  assign w_fin = (r_cnt == CW'(KBITS));
`else
  // Nothing left above cnt: trailing doublings cannot change R.
  assign w_fin = ((r_k >> r_cnt) == '0);
`endif

  always_comb begin
    w_nstate  = r_state;
    w_load    = 1'b0;
    w_iss_add = 1'b0;
    w_iss_dbl = 1'b0;
    w_r_q     = 1'b0;
    w_r_unit  = 1'b0;
    w_q_unit  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_load   = 1'b1;
          w_nstate = S_SCAN;
        end
      end
      S_SCAN: begin
`ifdef ECSM_CONST_TIME_EN
        if (w_fin) begin
          w_nstate = S_DONE;
        end else begin
          w_iss_add = 1'b1;
          w_nstate  = S_ADD_WAIT;
        end
`else
        if (w_fin) begin
          w_nstate = S_DONE;
        end else if (w_kbit && !r_rinf) begin
          w_iss_add = 1'b1;
          w_nstate  = S_ADD_WAIT;
        end else begin
          w_r_q     = w_kbit;
          w_iss_dbl = 1'b1;
          w_nstate  = S_DBL_WAIT;
        end
`endif
      end
      S_ADD_WAIT: begin
        if (add_done) begin
`ifdef ECSM_CONST_TIME_EN
          // Dummy adds are still paid for; only a set bit moves R.
          if (w_kbit) begin
            w_r_q    = r_rinf;
            w_r_unit = !r_rinf;
          end
`else
          w_r_unit = 1'b1;
`endif
          w_iss_dbl = 1'b1;
          w_nstate  = S_DBL_WAIT;
        end
      end
      S_DBL_WAIT: begin
        if (add_done) begin
          w_q_unit = 1'b1;
          w_nstate = S_SCAN;
        end
      end
      S_DONE: begin
        if (out_ready) w_nstate = S_IDLE;
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nstate;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k     <= '0;
      r_cnt   <= '0;
      r_qx    <= '0;
      r_qy    <= '0;
      r_rx    <= '0;
      r_ry    <= '0;
      r_rinf  <= 1'b1;
      r_start <= 1'b0;
      r_ax    <= '0;
      r_ay    <= '0;
      r_bx    <= '0;
      r_by    <= '0;
    end else begin
      r_start <= w_iss_add | w_iss_dbl;
      if (w_load) begin
        r_k    <= k;
        r_qx   <= px;
        r_qy   <= py;
        r_rx   <= '0;
        r_ry   <= '0;
        r_rinf <= 1'b1;
        r_cnt  <= '0;
      end
      if (w_r_q) begin
        r_rx   <= r_qx;
        r_ry   <= r_qy;
        r_rinf <= 1'b0;
      end
      if (w_r_unit) begin
        r_rx   <= add_rx;
        r_ry   <= add_ry;
        r_rinf <= add_rinf;
      end
      if (w_q_unit) begin
        r_qx  <= add_rx;
        r_qy  <= add_ry;
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_iss_add) begin
        r_ax <= r_rinf ? r_qx : r_rx;
        r_ay <= r_rinf ? r_qy : r_ry;
        r_bx <= r_qx;
        r_by <= r_qy;
      end
      if (w_iss_dbl) begin
        r_ax <= r_qx;
        r_ay <= r_qy;
        r_bx <= r_qx;
        r_by <= r_qy;
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign rx        = r_rinf ? '0 : r_rx;
  assign ry        = r_rinf ? '0 : r_ry;
  assign r_inf     = r_rinf;
  assign add_start = r_start;
  assign add_ax    = r_ax;
  assign add_ay    = r_ay;
  assign add_bx    = r_bx;
  assign add_by    = r_by;

endmodule

// File: tb/tb_ec_scalar_mult_p.sv
// tb_ec_scalar_mult_p: secp256k1 directed jobs plus a 16-bit toy-curve sweep.
// Behavioural point units answer add_start after a random latency.
module tb_ec_scalar_mult_p;

  typedef logic [255:0] u256;
  typedef struct packed {
    u256  x;
    u256  y;
    logic inf;
  } pt_t;

  localparam u256 P256 =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam u256 N256 =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;
  localparam u256 GX =
    256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
  localparam u256 GY =
    256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;
  localparam u256 G2X =
    256'hC6047F94_41ED7D6D_3045406E_95C07CD8_5C778E4B_8CEF3CA7_ABAC09B9_5C709EE5;
  localparam u256 G2Y =
    256'h1AE168FE_A63DC339_A3C58419_466CEAEE_F7F63265_3266D0E1_236431A9_50CFE52A;
  localparam u256 G3X =
    256'hF9308A01_9258C310_49344F85_F89D5229_B531C845_836F99B0_8601F113_BCE036F9;
  localparam u256 G3Y =
    256'h388F7B0F_632DE814_0FE337E6_2A37F356_6500A999_34C2231B_6CB9FD75_84B8E672;

  // Toy curve y^2 = x^3 + 2x + 2 over F17, G = (5,1), order 19.
  localparam u256 SP = 256'd17;
  localparam u256 SA = 256'd2;

  logic clk;
  logic rst_n;

  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic b_rinf_o, b_start, b_done, b_arinf;
  u256  b_px, b_py, b_k, b_rx, b_ry;
  u256  b_ax, b_ay, b_bx, b_by, b_arx, b_ary;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic        s_rinf_o, s_start, s_done, s_arinf;
  logic [15:0] s_px, s_py, s_k, s_rx, s_ry;
  logic [15:0] s_ax, s_ay, s_bx, s_by, s_arx, s_ary;

  int n_chk;
  int n_err;
  int b_adds, b_dbls, b_starts, b_force;
  bit b_busy, s_busy;

  ec_scalar_mult_p u_big (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .px(b_px), .py(b_py), .k(b_k),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .rx(b_rx), .ry(b_ry), .r_inf(b_rinf_o),
    .add_start(b_start),
    .add_ax(b_ax), .add_ay(b_ay), .add_bx(b_bx), .add_by(b_by),
    .add_done(b_done), .add_rx(b_arx), .add_ry(b_ary),
    .add_rinf(b_arinf)
  );

  ec_scalar_mult_p #(.WIDTH(16), .KBITS(16)) u_sml (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .px(s_px), .py(s_py), .k(s_k),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .rx(s_rx), .ry(s_ry), .r_inf(s_rinf_o),
    .add_start(s_start),
    .add_ax(s_ax), .add_ay(s_ay), .add_bx(s_bx), .add_by(s_by),
    .add_done(s_done), .add_rx(s_arx), .add_ry(s_ary),
    .add_rinf(s_arinf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic u256 mmul(input u256 a, input u256 b, input u256 p);
    logic [511:0] t;
    t = 512'(a) * 512'(b);
    t = t % 512'(p);
    return t[255:0];
  endfunction

  function automatic u256 madd(input u256 a, input u256 b, input u256 p);
    logic [256:0] s;
    s = 257'(a) + 257'(b);
    if (s >= 257'(p)) s = s - 257'(p);
    return s[255:0];
  endfunction

  function automatic u256 msub(input u256 a, input u256 b, input u256 p);
    return (a >= b) ? a - b : p - (b - a);
  endfunction

  function automatic u256 minv(input u256 a, input u256 p);
    u256 e, r;
    bit  go;
    e  = p - 256'd2;
    r  = 256'd1;
    go = 1'b0;
    for (int i = 255; i >= 0; i--) begin
      if (go) r = mmul(r, r, p);
      if (e[i]) begin
        r  = go ? mmul(r, a, p) : a;
        go = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic pt_t ec_add(input pt_t a, input pt_t b,
                                 input u256 p, input u256 ca);
    pt_t o;
    u256 lam, x3;
    if (a.inf) return b;
    if (b.inf) return a;
    o.x = '0;
    o.y = '0;
    o.inf = 1'b1;
    if (a.x == b.x) begin
      if (a.y != b.y || a.y == '0) return o;
      lam = madd(mmul(256'd3, mmul(a.x, a.x, p), p), ca, p);
      lam = mmul(lam, minv(madd(a.y, a.y, p), p), p);
    end else begin
      lam = mmul(msub(b.y, a.y, p), minv(msub(b.x, a.x, p), p), p);
    end
    x3 = msub(msub(mmul(lam, lam, p), a.x, p), b.x, p);
    o.x = x3;
    o.y = msub(mmul(lam, msub(a.x, x3, p), p), a.y, p);
    o.inf = 1'b0;
    return o;
  endfunction

  // Left-to-right reference, deliberately a different schedule from the DUT.
  function automatic pt_t ref_mul(input logic [15:0] kk);
    pt_t r, g;
    r.x = '0; r.y = '0; r.inf = 1'b1;
    g.x = 256'd5; g.y = 256'd1; g.inf = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      r = ec_add(r, r, SP, SA);
      if (kk[i]) r = ec_add(r, g, SP, SA);
    end
    if (r.inf) begin
      r.x = '0;
      r.y = '0;
    end
    return r;
  endfunction

  initial begin : big_unit
    pt_t pa, pb, res;
    int  lat;
    b_done = 0; b_arx = '0; b_ary = '0; b_arinf = 0; b_busy = 0;
    forever begin
      @(negedge clk);
      if (rst_n && b_start) begin
        b_busy = 1;
        b_starts++;
        if (b_ax == b_bx && b_ay == b_by) b_dbls++;
        else b_adds++;
        pa.x = b_ax; pa.y = b_ay; pa.inf = 1'b0;
        pb.x = b_bx; pb.y = b_by; pb.inf = 1'b0;
        res = ec_add(pa, pb, P256, '0);
        lat = (b_force != 0) ? b_force : $urandom_range(1, 20);
        repeat (lat) @(posedge clk);
        #1;
        b_done = 1; b_arx = res.x; b_ary = res.y; b_arinf = res.inf;
        @(posedge clk);
        #1;
        b_done = 0;
        b_busy = 0;
      end
    end
  end

  initial begin : sml_unit
    pt_t pa, pb, res;
    int  lat;
    s_done = 0; s_arx = '0; s_ary = '0; s_arinf = 0; s_busy = 0;
    forever begin
      @(negedge clk);
      if (rst_n && s_start) begin
        s_busy = 1;
        pa.x = 256'(s_ax); pa.y = 256'(s_ay); pa.inf = 1'b0;
        pb.x = 256'(s_bx); pb.y = 256'(s_by); pb.inf = 1'b0;
        res = ec_add(pa, pb, SP, SA);
        lat = $urandom_range(1, 2);
        repeat (lat) @(posedge clk);
        #1;
        s_done = 1; s_arx = res.x[15:0]; s_ary = res.y[15:0];
        s_arinf = res.inf;
        @(posedge clk);
        #1;
        s_done = 0;
        s_busy = 0;
      end
    end
  end

  task automatic chk(input string tag, input u256 obs, input u256 exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic big_job(input u256 kk, input int hold,
                         output u256 ox, output u256 oy,
                         output logic oinf);
    int t;
    b_adds = 0; b_dbls = 0; b_starts = 0;
    @(negedge clk);
    chk("b_in_ready", 256'(b_in_ready), 256'd1);
    b_k = kk; b_px = GX; b_py = GY; b_in_valid = 1;
    @(posedge clk);
    #1;
    b_in_valid = 0;
    t = 0;
    while (b_out_valid !== 1'b1 && t < 40000) begin
      @(negedge clk);
      t++;
    end
    chk("b_out_valid", 256'(b_out_valid), 256'd1);
    ox = b_rx; oy = b_ry; oinf = b_rinf_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 256'(b_out_valid), 256'd1);
      chk("hold_rx", b_rx, ox);
      chk("hold_ry", b_ry, oy);
      chk("hold_inf", 256'(b_rinf_o), 256'(oinf));
    end
    b_out_ready = 1;
    @(posedge clk);
    #1;
    b_out_ready = 0;
    chk("b_back_idle", 256'(b_in_ready), 256'd1);
    chk("b_valid_drop", 256'(b_out_valid), 256'd0);
  endtask

  task automatic sml_job(input logic [15:0] kk, output u256 ox,
                         output u256 oy, output logic oinf);
    int t;
    @(negedge clk);
    s_k = kk; s_px = 16'd5; s_py = 16'd1; s_in_valid = 1;
    @(posedge clk);
    #1;
    s_in_valid = 0;
    t = 0;
    while (s_out_valid !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("s_out_valid", 256'(s_out_valid), 256'd1);
    ox = 256'(s_rx); oy = 256'(s_ry); oinf = s_rinf_o;
    s_out_ready = 1;
    @(posedge clk);
    #1;
    s_out_ready = 0;
  endtask

  initial begin : main
    u256  ox, oy;
    logic oi;
    pt_t  e;
    int   t, s0;
    bit   seen_ov, seen_st;
    logic [15:0] kk;

    n_chk = 0; n_err = 0; b_force = 0;
    b_adds = 0; b_dbls = 0; b_starts = 0;
    rst_n = 0;
    b_in_valid = 0; b_out_ready = 0; b_k = '0; b_px = '0; b_py = '0;
    s_in_valid = 0; s_out_ready = 0; s_k = '0; s_px = '0; s_py = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 256'(b_in_ready), 256'd1);
    chk("rst_valid", 256'(b_out_valid), 256'd0);
    chk("rst_start", 256'(b_start), 256'd0);
    chk("rst_inf", 256'(b_rinf_o), 256'd1);
    chk("rst_rx", b_rx, '0);
    chk("rst_ry", b_ry, '0);
    chk("rst_ax", b_ax, '0);
    chk("rst_by", b_by, '0);
    chk("rst_s_inf", 256'(s_rinf_o), 256'd1);
    rst_n = 1;
    @(negedge clk);

    big_job(256'd1, 0, ox, oy, oi);
    chk("k1_x", ox, GX);
    chk("k1_y", oy, GY);
    chk("k1_inf", 256'(oi), 256'd0);
`ifdef ECSM_CONST_TIME_EN
    chk("k1_ops", 256'(b_starts), 256'd512);
`else
    chk("k1_dbls", 256'(b_dbls), 256'd1);
    chk("k1_ops", 256'(b_starts), 256'd1);
`endif

    big_job(256'd2, 0, ox, oy, oi);
    chk("k2_x", ox, G2X);
    chk("k2_y", oy, G2Y);
    chk("k2_inf", 256'(oi), 256'd0);
`ifdef ECSM_CONST_TIME_EN
    chk("k2_ops", 256'(b_starts), 256'd512);
`else
    chk("k2_adds", 256'(b_adds), 256'd0);
    chk("k2_dbls", 256'(b_dbls), 256'd2);
`endif

    big_job(256'd0, 0, ox, oy, oi);
    chk("k0_x", ox, '0);
    chk("k0_y", oy, '0);
    chk("k0_inf", 256'(oi), 256'd1);
`ifdef ECSM_CONST_TIME_EN
    chk("k0_ops", 256'(b_starts), 256'd512);
`else
    chk("k0_ops", 256'(b_starts), 256'd0);
`endif

    big_job(N256 - 256'd1, 10, ox, oy, oi);
    chk("kn1_x", ox, GX);
    chk("kn1_y", oy, P256 - GY);
    chk("kn1_inf", 256'(oi), 256'd0);

    // Abort a long job around bit 100 with an add still in flight.
    b_adds = 0; b_dbls = 0; b_starts = 0;
    @(negedge clk);
    b_k = '1; b_px = GX; b_py = GY; b_in_valid = 1;
    @(posedge clk);
    #1;
    b_in_valid = 0;
    t = 0;
    while (b_dbls < 100 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("reach_bit100", 256'(b_dbls >= 100), 256'd1);
    b_force = 15;
    s0 = b_starts;
    t = 0;
    while (b_starts == s0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("inflight", 256'(b_busy), 256'd1);
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", 256'(b_out_valid), 256'd0);
    chk("mid_rst_start", 256'(b_start), 256'd0);
    chk("mid_rst_inf", 256'(b_rinf_o), 256'd1);
    chk("mid_rst_ax", b_ax, '0);
    @(negedge clk);
    rst_n = 1;
    seen_ov = 0; seen_st = 0;
    t = 0;
    while (b_busy && t < 100) begin
      @(negedge clk);
      t++;
      seen_ov |= b_out_valid;
      seen_st |= b_start;
    end
    repeat (2) begin
      @(negedge clk);
      seen_ov |= b_out_valid;
      seen_st |= b_start;
    end
    b_force = 0;
    chk("stale_drain", 256'(b_busy), 256'd0);
    chk("abort_no_out", 256'(seen_ov), 256'd0);
    chk("stale_no_op", 256'(seen_st), 256'd0);
    chk("stale_ready", 256'(b_in_ready), 256'd1);
    chk("stale_inf", 256'(b_rinf_o), 256'd1);

    big_job(256'd3, 0, ox, oy, oi);
    chk("k3_x", ox, G3X);
    chk("k3_y", oy, G3Y);
    chk("k3_inf", 256'(oi), 256'd0);

    sml_job(16'd2, ox, oy, oi);
    chk("s2_x", ox, 256'd6);
    chk("s2_y", oy, 256'd3);
    sml_job(16'd18, ox, oy, oi);
    chk("s18_x", ox, 256'd5);
    chk("s18_y", oy, 256'd16);
    sml_job(16'd19, ox, oy, oi);
    chk("s19_inf", 256'(oi), 256'd1);
    chk("s19_x", ox, '0);

    for (int i = 0; i < 200; i++) begin
      kk = 16'($urandom_range(0, 65535));
      e = ref_mul(kk);
      sml_job(kk, ox, oy, oi);
      chk("srnd_x", ox, e.x);
      chk("srnd_y", oy, e.y);
      chk("srnd_inf", 256'(oi), 256'(e.inf));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
